ecc_point_ctrl: RTL and testbench
=================================

# ecc_point_ctrl

Sequencer directly upstream of the GF arithmetic unit (GFAU). It accepts one affine elliptic-curve point operation (P+Q or 2P) over a prime field and breaks it into a fixed micro-sequence of GFAU add/sub/mult/div requests. It keeps the intermediates in a small internal register file and returns the result point to the top-level ECC scheduler.

## Interface
- WIDTH, 32, field element width; matches GFAU operand width
- TIMEOUT, 4096, maximum cycles to wait for one GFAU completion before aborting
- i_clk  in  1  clock
- i_rst  in  1  asynchronous, active-low reset
- start  in  1  request pulse; accepted only when busy=0
- mode  in  1  0 = add P+Q, 1 = double 2P
- x1, y1, x2, y2  in  WIDTH each  operand points; x2/y2 ignored when mode=1
- a  in  WIDTH  curve coefficient a
- p  in  WIDTH  field prime
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- x3, y3  out  WIDTH  result point; held until the next accepted start
- inf  out  1  result is the point at infinity; valid with done
- err  out  1  abort (timeout or unsupported case); valid with done
- in_0, in_1  out  WIDTH  GFAU operands
- prime  out  WIDTH  GFAU modulus; equals the latched p
- operation_select  out  2  00 add, 01 sub, 10 mult, 11 div (in_0 op in_1)
- done_from_control  out  1  one-cycle issue strobe to GFAU
- result  in  WIDTH  GFAU result
- done_to_control  in  1  GFAU completion strobe

## Operation
- Register file: X1 Y1 X2 Y2 A (latched on start), T0 T1 L (scratch), X3 Y3.
- States: IDLE → CHECK → ISSUE ⇄ WAIT → FINISH → IDLE.
- IDLE: start=1 latches all inputs; next state is CHECK.
- CHECK (1 cycle), evaluated in this priority order:
  - mode=0, x1==x2, y1≠y2: go to FINISH with inf=1.
  - mode=0, x1==x2, y1==y2: run the doubling sequence.
  - mode=1, y1==0: go to FINISH with inf=1.
  - Otherwise: step=0, go to ISSUE.
- Add sequence (9 steps): T0=Y2−Y1; T1=X2−X1; L=T0/T1; T0=L·L; T0=T0−X1; X3=T0−X2; T1=X1−X3; T1=L·T1; Y3=T1−Y1.
- Double sequence (12 steps): T0=X1·X1; T1=T0+T0; T0=T1+T0; T0=T0+A; T1=Y1+Y1; L=T0/T1; T0=L·L; T1=X1+X1; X3=T0−T1; T1=X1−X3; T1=L·T1; Y3=T1−Y1.
- ISSUE (1 cycle): drive in_0, in_1 and operation_select for the current step; done_from_control=1; clear the wait counter.
- WAIT:
  - in_0, in_1, operation_select and prime are held stable.
  - On done_to_control=1, result is written to the step's destination register.
  - Then step increments and the FSM returns to ISSUE, or goes to FINISH after the last step.
- Timeout: the wait counter reaching TIMEOUT aborts to FINISH with err=1, x3=y3=0.
- FINISH (1 cycle): done=1; x3/y3 update from X3/Y3 (or 0 if inf or err); busy=0 in the following cycle.
- done_to_control outside WAIT is ignored.
- start while busy is ignored.
- A reset assertion mid-operation returns the block to IDLE immediately with no done pulse.
- Arithmetic is fully delegated to the GFAU; this block performs only equality compares.

## Timing
- Reset values: busy, done, inf, err, done_from_control = 0; x3, y3, in_0, in_1, prime = 0; operation_select = 00; state = IDLE.
- Per step: 1 issue cycle plus Lk cycles in WAIT, where Lk ≥ 1 is counted from the issue cycle to done_to_control inclusive.
- Total latency from the start edge to done = 1 (CHECK) + Σ(1+Lk) + 1.
- Trivial inf cases: done appears 2 cycles after start, with no GFAU issue.
- done_from_control is never asserted in two consecutive cycles.

## Configuration
- ECC_PT_DOUBLE_EN defined: doubling ROM is present; mode=1 and the add case with x1==x2, y1==y2 run the doubling sequence.
- Not defined: both of those cases go CHECK→FINISH with err=1 and no GFAU issue; the add ROM only is built.

## Structure
- Package ecc_pkg holds:
  - the operation_select encoding constants;
  - the FSM state enum;
  - the register-index enum;
  - the micro-instruction struct {op, src0, src1, dst};
  - the sequence lengths ADD_STEPS=9 and DBL_STEPS=12.
- Sub-module ecc_ucode_rom: combinational (mode, step) → micro-instruction.

## Test plan
Bench uses a behavioural GFAU model with programmable latency; curve p=97, a=2.
- Double, mode=1, (3,6), GFAU latency 1 → x3=80, y3=10, inf=0, err=0; exactly 12 issue strobes; done at cycle 1+12·2+1 after start.
- Add, mode=0, (3,6)+(80,10), latency 5 → x3=80, y3=87; 9 strobes; operands stable throughout every WAIT.
- Add (80,10)+(80,87) → inf=1, x3=y3=0, done 2 cycles after start, no strobes.
- Add (3,6)+(3,6) → with ECC_PT_DOUBLE_EN: x3=80, y3=10; without: err=1, no strobes.
- GFAU model never responds, TIMEOUT=16 → err=1 after 16 wait cycles of step 0; busy drops one cycle after done.
- Reset pulsed during WAIT of step 4, then a new add start → no done from the aborted operation; the new result is correct; a spurious done_to_control while IDLE causes no state change.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared types and constants for the elliptic-curve point sequencer.
// Holds the GFAU operation encoding, FSM states, register-file indices,
// the micro-instruction format and the sequence lengths.
package ecc_pkg;

  // GFAU operation_select encoding (in_0 op in_1)
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int ADD_STEPS = 9;
  localparam int DBL_STEPS = 12;
  localparam int NUM_REGS  = 10;
  localparam int STEP_W    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_e;

  typedef enum logic [3:0] {
    R_X1 = 4'd0,
    R_Y1 = 4'd1,
    R_X2 = 4'd2,
    R_Y2 = 4'd3,
    R_A  = 4'd4,
    R_T0 = 4'd5,
    R_T1 = 4'd6,
    R_L  = 4'd7,
    R_X3 = 4'd8,
    R_Y3 = 4'd9
  } reg_e;

  typedef struct packed {
    logic [1:0] op;
    reg_e       src0;
    reg_e       src1;
    reg_e       dst;
  } uinstr_t;

  // Builds a micro-instruction written as dst = src0 op src1.
  function automatic uinstr_t mk_ui(input logic [1:0] op, input reg_e dst,
                                    input reg_e src0, input reg_e src1);
    uinstr_t u;
    u.op   = op;
    u.src0 = src0;
    u.src1 = src1;
    u.dst  = dst;
    return u;
  endfunction

endpackage

// File: rtl/ecc_point_ctrl_if.sv
// ecc_point_ctrl_if: request/response bus between the point sequencer
// (master) and the GF arithmetic unit (slave).
interface ecc_point_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] prime;
  logic [1:0]       operation_select;
  logic             done_from_control;
  logic [WIDTH-1:0] result;
  logic             done_to_control;

  modport master (
    output in_0, in_1, prime, operation_select, done_from_control,
    input  result, done_to_control
  );

  modport slave (
    input  in_0, in_1, prime, operation_select, done_from_control,
    output result, done_to_control
  );
endinterface

// File: rtl/ecc_ucode_rom.sv
// ecc_ucode_rom: combinational (sequence, step) -> micro-instruction table.
// The doubling table exists only when ECC_PT_DOUBLE_EN is defined; otherwise
// only the point-addition table is built.
module ecc_ucode_rom
  import ecc_pkg::*;
(
  input  logic              dbl_i,
  input  logic [STEP_W-1:0] step_i,
  output uinstr_t           instr_o
);

  // Table lookup; unreachable entries fall back to a harmless default.
  always_comb begin
    instr_o = mk_ui(OP_ADD, R_T0, R_X1, R_X1);
    if (!dbl_i) begin
      case (step_i)
        4'd0:    instr_o = mk_ui(OP_SUB, R_T0, R_Y2, R_Y1);
        4'd1:    instr_o = mk_ui(OP_SUB, R_T1, R_X2, R_X1);
        4'd2:    instr_o = mk_ui(OP_DIV, R_L,  R_T0, R_T1);
        4'd3:    instr_o = mk_ui(OP_MUL, R_T0, R_L,  R_L);
        4'd4:    instr_o = mk_ui(OP_SUB, R_T0, R_T0, R_X1);
        4'd5:    instr_o = mk_ui(OP_SUB, R_X3, R_T0, R_X2);
        4'd6:    instr_o = mk_ui(OP_SUB, R_T1, R_X1, R_X3);
        4'd7:    instr_o = mk_ui(OP_MUL, R_T1, R_L,  R_T1);
        4'd8:    instr_o = mk_ui(OP_SUB, R_Y3, R_T1, R_Y1);
        default: ;
      endcase
    end
`ifdef ECC_PT_DOUBLE_EN
    else begin
      case (step_i)
        4'd0:    instr_o = mk_ui(OP_MUL, R_T0, R_X1, R_X1);
        4'd1:    instr_o = mk_ui(OP_ADD, R_T1, R_T0, R_T0);
        4'd2:    instr_o = mk_ui(OP_ADD, R_T0, R_T1, R_T0);
        4'd3:    instr_o = mk_ui(OP_ADD, R_T0, R_T0, R_A);
        4'd4:    instr_o = mk_ui(OP_ADD, R_T1, R_Y1, R_Y1);
        4'd5:    instr_o = mk_ui(OP_DIV, R_L,  R_T0, R_T1);
        4'd6:    instr_o = mk_ui(OP_MUL, R_T0, R_L,  R_L);
        4'd7:    instr_o = mk_ui(OP_ADD, R_T1, R_X1, R_X1);
        4'd8:    instr_o = mk_ui(OP_SUB, R_X3, R_T0, R_T1);
        4'd9:    instr_o = mk_ui(OP_SUB, R_T1, R_X1, R_X3);
        4'd10:   instr_o = mk_ui(OP_MUL, R_T1, R_L,  R_T1);
        4'd11:   instr_o = mk_ui(OP_SUB, R_Y3, R_T1, R_Y1);
        default: ;
      endcase
    end
`endif
  end

endmodule

// File: rtl/ecc_point_ctrl.sv
// ecc_point_ctrl: sequences one affine point add (P+Q) or double (2P) into
// GFAU requests, keeping intermediates in a small register file.
// Optional feature: ECC_PT_DOUBLE_EN enables the doubling sequence; without
// it, doubling cases finish immediately with err=1.
module ecc_point_ctrl
  import ecc_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] y2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3,
  output logic             inf,
  output logic             err,
  ecc_point_ctrl_if.master gfau
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              dbl_q, dbl_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  prime_q, prime_d;
  logic [WIDTH-1:0]  x3_q, x3_d, y3_q, y3_d;
  logic              inf_q, inf_d, err_q, err_d;
  logic [WIDTH-1:0]  rf_q [NUM_REGS];
  logic [WIDTH-1:0]  rf_d [NUM_REGS];

  uinstr_t           instr;
  logic [STEP_W-1:0] last_step;
  logic              x_eq, y_eq, y1_zero, active;

  ecc_ucode_rom u_rom (
    .dbl_i   (dbl_q),
    .step_i  (step_q),
    .instr_o (instr)
  );

  assign last_step = dbl_q ? STEP_W'(DBL_STEPS - 1) : STEP_W'(ADD_STEPS - 1);
  assign x_eq      = (rf_q[R_X1] == rf_q[R_X2]);
  assign y_eq      = (rf_q[R_Y1] == rf_q[R_Y2]);
  assign y1_zero   = (rf_q[R_Y1] == '0);
  assign active    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Scheduler-facing outputs
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FINISH);
  assign x3   = x3_q;
  assign y3   = y3_q;
  assign inf  = inf_q;
  assign err  = err_q;

  // GFAU operands come straight from the register file; they cannot change
  // during WAIT because the only write happens on the completing edge.
  assign gfau.in_0              = active ? rf_q[instr.src0] : '0;
  assign gfau.in_1              = active ? rf_q[instr.src1] : '0;
  assign gfau.operation_select  = active ? instr.op : OP_ADD;
  assign gfau.prime             = prime_q;
  assign gfau.done_from_control = (state_q == ST_ISSUE);

  // Next-state logic, register-file writes and result capture
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    dbl_d   = dbl_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    prime_d = prime_q;
    x3_d    = x3_q;
    y3_d    = y3_q;
    inf_d   = inf_q;
    err_d   = err_q;
    rf_d    = rf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rf_d[R_X1] = x1;
          rf_d[R_Y1] = y1;
          rf_d[R_X2] = x2;
          rf_d[R_Y2] = y2;
          rf_d[R_A]  = a;
          prime_d    = p;
          mode_d     = mode;
          dbl_d      = 1'b0;
          step_d     = '0;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if ((!mode_q && x_eq && !y_eq) || (mode_q && y1_zero)) begin
          inf_d   = 1'b1;
          err_d   = 1'b0;
          x3_d    = '0;
          y3_d    = '0;
          state_d = ST_FINISH;
        end else if (mode_q || (x_eq && y_eq)) begin
`ifdef ECC_PT_DOUBLE_EN
          dbl_d   = 1'b1;
          step_d  = '0;
          state_d = ST_ISSUE;
`else
          inf_d   = 1'b0;
          err_d   = 1'b1;
          x3_d    = '0;
          y3_d    = '0;
          state_d = ST_FINISH;
`endif
        end else begin
          dbl_d   = 1'b0;
          step_d  = '0;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (gfau.done_to_control) begin
          rf_d[instr.dst] = gfau.result;
          if (step_q == last_step) begin
            inf_d   = 1'b0;
            err_d   = 1'b0;
            x3_d    = rf_d[R_X3];
            y3_d    = rf_d[R_Y3];
            state_d = ST_FINISH;
          end else begin
            step_d  = step_q + STEP_W'(1);
            state_d = ST_ISSUE;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          inf_d   = 1'b0;
          err_d   = 1'b1;
          x3_d    = '0;
          y3_d    = '0;
          state_d = ST_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      dbl_q   <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      prime_q <= '0;
      x3_q    <= '0;
      y3_q    <= '0;
      inf_q   <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dbl_q   <= dbl_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      prime_q <= prime_d;
      x3_q    <= x3_d;
      y3_q    <= y3_d;
      inf_q   <= inf_d;
      err_q   <= err_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_ecc_point_ctrl.sv
// tb_ecc_point_ctrl: directed point operations on y^2 = x^3 + 2x + b over
// GF(97) with a behavioural GFAU of programmable latency; expected results
// are queued on start and checked when done appears.
module tb_ecc_point_ctrl;
  import ecc_pkg::*;

  localparam int          W   = 32;
  localparam int          TMO = 16;
  localparam logic [W-1:0] PR = 32'd97;
  localparam logic [W-1:0] CA = 32'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0;
  logic [W-1:0] a = CA, p = PR;
  logic         busy, done, inf, err;
  logic [W-1:0] x3, y3;

  ecc_point_ctrl_if #(.WIDTH(W)) gf ();

  ecc_point_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .start (start),
    .mode  (mode),
    .x1    (x1),
    .y1    (y1),
    .x2    (x2),
    .y2    (y2),
    .a     (a),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .x3    (x3),
    .y3    (y3),
    .inf   (inf),
    .err   (err),
    .gfau  (gf)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int done_cnt = 0;
  int lat_cfg = 1;
  bit never = 1'b0;

  typedef struct {
    string        name;
    logic [W-1:0] x3, y3;
    logic         inf, err;
    int           lat;
    int           nstr;
    int           start_cyc;
    int           str_base;
  } exp_t;

  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic longint modinv(input longint b, input longint q);
    longint r, e, bb;
    r = 1; e = q - 2; bb = b % q;
    while (e > 0) begin
      if ((e & 1) != 0) r = (r * bb) % q;
      bb = (bb * bb) % q;
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] gfop(input logic [1:0] s, input logic [W-1:0] a0,
                                       input logic [W-1:0] b0, input logic [W-1:0] m);
    longint x, y, q, r;
    x = longint'(a0); y = longint'(b0); q = longint'(m);
    case (s)
      2'b00:   r = (x + y) % q;
      2'b01:   r = (x - y + q) % q;
      2'b10:   r = (x * y) % q;
      default: r = (x * modinv(y, q)) % q;
    endcase
    return r[W-1:0];
  endfunction

  // Behavioural GFAU: answers Lk cycles after the issue cycle, checks that
  // the request is held stable while it is outstanding.
  initial begin : gfau_model
    int rem;
    bit prev_dfc;
    logic [W-1:0] c0, c1, cp;
    logic [1:0]   cs;
    rem = 0; prev_dfc = 1'b0;
    c0 = '0; c1 = '0; cp = '0; cs = '0;
    gf.done_to_control = 1'b0;
    gf.result = '0;
    forever begin
      @(posedge clk);
      #1;
      gf.done_to_control = 1'b0;
      if (!rst_n) begin
        rem = 0;
        prev_dfc = 1'b0;
      end else if (gf.done_from_control) begin
        strobes++;
        chk("strobe_not_back_to_back", {31'd0, prev_dfc}, 0);
        prev_dfc = 1'b1;
        c0 = gf.in_0; c1 = gf.in_1; cs = gf.operation_select; cp = gf.prime;
        rem = never ? -1 : lat_cfg;
      end else begin
        prev_dfc = 1'b0;
        if (rem > 0) begin
          checks++;
          if (gf.in_0 !== c0 || gf.in_1 !== c1 || gf.operation_select !== cs || gf.prime !== PR) begin
            errors++;
            $display("FAIL wait_operands_stable: got %0d,%0d op%0d p%0d required %0d,%0d op%0d p%0d",
                     gf.in_0, gf.in_1, gf.operation_select, gf.prime, c0, c1, cs, PR);
          end
          rem--;
          if (rem == 0) begin
            gf.result = gfop(cs, c0, c1, cp);
            gf.done_to_control = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: pops one expectation per done pulse.
  initial begin : monitor
    exp_t e;
    bit prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        chk("busy_low_after_done", {31'd0, busy}, 0);
        prev_done = 1'b0;
      end
      if (rst_n && done) begin
        done_cnt++;
        prev_done = 1'b1;
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 required no done");
        end else begin
          e = sbq.pop_front();
          chk({e.name, "_x3"}, x3, e.x3);
          chk({e.name, "_y3"}, y3, e.y3);
          chk({e.name, "_inf"}, {31'd0, inf}, {31'd0, e.inf});
          chk({e.name, "_err"}, {31'd0, err}, {31'd0, e.err});
          chk({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
          chk({e.name, "_strobes"}, strobes - e.str_base, e.nstr);
          $display("op %s: x3=%0d y3=%0d inf=%0d err=%0d lat=%0d strobes=%0d",
                   e.name, x3, y3, inf, err, cyc - e.start_cyc, strobes - e.str_base);
        end
      end
    end
  end

  task automatic run_op(input string nm, input bit md,
                        input logic [W-1:0] ax1, input logic [W-1:0] ay1,
                        input logic [W-1:0] ax2, input logic [W-1:0] ay2,
                        input int lat, input bit nev, input bit glitch,
                        input logic [W-1:0] ex3, input logic [W-1:0] ey3,
                        input logic einf, input logic eerr,
                        input int elat, input int estr);
    exp_t e;
    int d0;
    bit got;
    lat_cfg = lat;
    never = nev;
    @(posedge clk);
    #1;
    mode = md; x1 = ax1; y1 = ay1; x2 = ax2; y2 = ay2; start = 1'b1;
    e.name = nm; e.x3 = ex3; e.y3 = ey3; e.inf = einf; e.err = eerr;
    e.lat = elat; e.nstr = estr; e.start_cyc = cyc; e.str_base = strobes;
    sbq.push_back(e);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      // A start pulse with other operands while busy must be ignored.
      if (glitch && i == 4 && busy) begin
        x1 = 32'd5; y1 = 32'd7; mode = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done_cnt != d0) got = 1'b1;
    end
    start = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_done_timeout: got no done required done within 300 cycles", nm);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin : stim
    int b;
    bit got;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_inf", {31'd0, inf}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_dfc", {31'd0, gf.done_from_control}, 0);
    chk("rst_x3", x3, 0);
    chk("rst_y3", y3, 0);
    chk("rst_in0", gf.in_0, 0);
    chk("rst_in1", gf.in_1, 0);
    chk("rst_prime", gf.prime, 0);
    chk("rst_opsel", {30'd0, gf.operation_select}, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

`ifdef ECC_PT_DOUBLE_EN
    run_op("dbl_3_6", 1'b1, 3, 6, 0, 0, 1, 1'b0, 1'b1, 80, 10, 1'b0, 1'b0, 26, 12);
`else
    run_op("dbl_3_6", 1'b1, 3, 6, 0, 0, 1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b1, 2, 0);
`endif
    run_op("add_3_6_80_10", 1'b0, 3, 6, 80, 10, 5, 1'b0, 1'b0, 80, 87, 1'b0, 1'b0, 56, 9);
    run_op("add_inverse", 1'b0, 80, 10, 80, 87, 1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 2, 0);
`ifdef ECC_PT_DOUBLE_EN
    run_op("add_same_pt", 1'b0, 3, 6, 3, 6, 2, 1'b0, 1'b0, 80, 10, 1'b0, 1'b0, 38, 12);
`else
    run_op("add_same_pt", 1'b0, 3, 6, 3, 6, 2, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 2, 0);
`endif
    run_op("timeout", 1'b0, 3, 6, 80, 10, 1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b1, 19, 1);

    // Abort an addition by reset while step 4 is outstanding.
    never = 1'b0;
    lat_cfg = 5;
    @(posedge clk);
    #1;
    mode = 1'b0; x1 = 3; y1 = 6; x2 = 80; y2 = 10; start = 1'b1;
    b = strobes;
    @(posedge clk);
    #1;
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      #1;
      if (strobes - b >= 5) got = 1'b1;
    end
    chk("reached_step4", {31'd0, got}, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_x3", x3, 0);
    chk("midrst_dfc", {31'd0, gf.done_from_control}, 0);
    rst_n = 1'b1;
    $display("op abort_by_reset: strobes_before_reset=%0d", strobes - b);

    // Spurious completion while idle must not start anything.
    @(posedge clk);
    #2;
    gf.result = 32'd55;
    gf.done_to_control = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spurious_idle_busy", {31'd0, busy}, 0);
    end
    $display("op spurious_done_to_control: busy=%0d", busy);

    run_op("add_after_reset", 1'b0, 3, 6, 80, 10, 3, 1'b0, 1'b0, 80, 87, 1'b0, 1'b0, 38, 9);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
